// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor z = x - y, one digit per clock, LSD first.
// Optional macro BCD_SUB_CHECK_EN: reject non-BCD operands with err and an immediate done.
module bcd_serial_sub #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4*DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow,
  output logic             err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] x_reg, y_reg, z_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             b_reg, borrow_reg, busy_reg, done_reg;

  logic [4:0]       t_next;
  logic [3:0]       digit_next;
  logic             skip;

  // 5-bit two's-complement difference; bit 4 is the sign, hence the new borrow.
  assign t_next     = {1'b0, x_reg[3:0]} - {1'b0, y_reg[3:0]} - {4'b0000, b_reg};
  assign digit_next = t_next[4] ? (t_next[3:0] + 4'd10) : t_next[3:0];

`ifdef BCD_SUB_CHECK_EN
  logic              err_reg;
  logic [DIGITS-1:0] bad_digit;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign bad_digit[gi] = (x[4*gi +: 4] > 4'd9) || (y[4*gi +: 4] > 4'd9);
  end
  assign skip = |bad_digit;
  assign err  = err_reg;
`else
  assign skip = 1'b0;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      cnt_reg    <= '0;
      b_reg      <= 1'b0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg      <= x;
            y_reg      <= y;
            z_reg      <= '0;
            cnt_reg    <= '0;
            b_reg      <= 1'b0;
            borrow_reg <= 1'b0;
            busy_reg   <= 1'b1;
            done_reg   <= skip;
            state_reg  <= skip ? DONE : RUN;
`ifdef BCD_SUB_CHECK_EN
            err_reg    <= skip;
`endif
          end
        end
        RUN: begin
          x_reg   <= x_reg >> 4;
          y_reg   <= y_reg >> 4;
          // New digit enters at the top so digit 0 ends up in [3:0].
          z_reg   <= (z_reg >> 4) | (WIDTH'(digit_next) << (WIDTH-4));
          b_reg   <= t_next[4];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            borrow_reg <= t_next[4];
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign z      = z_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Bench for bcd_serial_sub: integer-arithmetic reference model, per-cycle compare, directed + random ops.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 4*DIGITS;
  localparam int LAT    = DIGITS + 1;
`ifdef BCD_SUB_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             busy, done, borrow, err;
  logic [WIDTH-1:0] z;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .borrow(borrow), .err(err)
  );

  initial forever #5 clk = ~clk;

  int cyc    = 0;
  int n_vec  = 0;
  int n_bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [WIDTH-1:0] v);
    int r = 0;
    for (int i = DIGITS-1; i >= 0; i--) r = r*10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] int2bcd(input int v);
    logic [WIDTH-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(input logic [WIDTH-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // {borrow, z}: plain integer difference, wrapped to ten's complement when negative.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int d = bcd2int(a) - bcd2int(b);
    bit br = (d < 0);
    if (br) d = d + 10**DIGITS;
    return {br, int2bcd(d)};
  endfunction

  function automatic logic [WIDTH-1:0] rand_bcd();
    logic [WIDTH-1:0] r = '0;
    int sel = $urandom_range(0, 7);
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == 0)      r[4*i +: 4] = 4'd9;
      else if (sel == 1) r[4*i +: 4] = 4'd0;
      else               r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Reference model: which starts are accepted, when done falls, what the result is.
  bit               m_active = 1'b0;
  int               m_acc = 0, m_done_cyc = 0;
  logic [WIDTH-1:0] m_z = '0, m_x = '0, m_y = '0;
  logic             m_b = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_z      <= '0;
      m_b      <= 1'b0;
      m_err    <= 1'b0;
    end else if (start && (!m_active || cyc > m_done_cyc)) begin
      m_active <= 1'b1;
      m_acc    <= cyc;
      m_x      <= x;
      m_y      <= y;
      if (CHECK && !(is_bcd(x) && is_bcd(y))) begin
        m_z        <= '0;
        m_b        <= 1'b0;
        m_err      <= 1'b1;
        m_done_cyc <= cyc + 1;
      end else begin
        {m_b, m_z} <= ref_sub(x, y);
        m_err      <= 1'b0;
        m_done_cyc <= cyc + DIGITS + 1;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    bit eb, ed;
    if (cyc > 0) begin
      eb = m_active && (cyc > m_acc) && (cyc <= m_done_cyc);
      ed = m_active && (cyc == m_done_cyc);
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (ed || !eb) begin
        chk("z", z, m_z);
        chk("borrow", borrow, m_b);
        chk("err", err, m_err);
      end
      if (ed) $display("txn x=%h y=%h -> z=%h borrow=%b err=%b (cycle %0d)", m_x, m_y, z, borrow, err, cyc);
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1'b1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ez, input logic eb, input logic ee, input int elat);
    int c;
    @(posedge clk); #1;
    x = a; y = b; start = 1'b1; c = cyc;
    @(posedge clk); #1;
    start = 1'b0; x = WIDTH'($urandom); y = WIDTH'($urandom);
    wait_done();
    chk("op_latency", cyc - c, elat);
    chk("op_z", z, ez);
    chk("op_borrow", borrow, eb);
    chk("op_err", err, ee);
  endtask

  task automatic rand_op();
    bit bad = 1'b0;
    bit spam = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    x = rand_bcd(); y = rand_bcd();
    if (CHECK && $urandom_range(0, 7) == 0) begin
      bad = 1'b1;
      x[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = WIDTH'($urandom); y = WIDTH'($urandom);
    if (spam && !bad) begin
      @(posedge clk); #1;
      start = 1'b1; x = rand_bcd(); y = rand_bcd();
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z", z, '0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_err", err, 1'b0);

    chk("model_3087", ref_sub(16'h4321, 16'h1234), {1'b0, 16'h3087});
    chk("model_9999", ref_sub(16'h0000, 16'h0001), {1'b1, 16'h9999});
    chk("model_0999", ref_sub(16'h1000, 16'h0001), {1'b0, 16'h0999});

    run_op(16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0, LAT);
    run_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, LAT);
    run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, LAT);
    run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, LAT);

    // Start while busy is dropped; the start right after done is taken.
    @(posedge clk); #1;
    x = 16'h4321; y = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = '0; y = '0;
    @(posedge clk); #1;
    x = 16'h5555; y = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("ignored_start_z", z, 16'h3087);
    run_op(16'h5555, 16'h1111, 16'h4444, 1'b0, 1'b0, LAT);

    // Reset two cycles into RUN aborts with no done pulse.
    @(posedge clk); #1;
    x = 16'h8765; y = 16'h4321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_z", z, '0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op(16'h8765, 16'h4321, 16'h4444, 1'b0, 1'b0, LAT);

`ifdef BCD_SUB_CHECK_EN
    run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
    run_op(16'h0002, 16'h0005, 16'h9997, 1'b1, 1'b0, LAT);
`else
    run_op(16'h0002, 16'h0005, 16'h9997, 1'b1, 1'b0, LAT);
`endif

    for (int i = 0; i < 40; i++) rand_op();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
